// File: rtl/parking_gate_controller.sv
// parking_gate_controller
// Sequences the entry and exit barriers of the car park. One gate is granted at
// a time, with round-robin arbitration between the two sides. Cars admitted but
// not yet parked are counted in in_transit. Entry is refused once every free
// slot has already been promised to one of those cars.
//
// Handshake / sensor semantics: every request and pass input is a level. A grant
// is taken in IDLE. Once granted, the gate stays open until its pass sensor
// cycles, or until the open timeout expires. Dropping a request after the grant
// does not abort the cycle.
module parking_gate_controller #(
  parameter int OPEN_CYCLES  = 1000,
  parameter int GUARD_CYCLES = 50,
  parameter int SLOTS        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_free,
  input  logic       i_entry_req,
  input  logic       i_exit_req,
  input  logic       i_entry_pass,
  input  logic       i_exit_pass,
  output logic       o_entry_open,
  output logic       o_exit_open,
  output logic [3:0] o_avail,
  output logic       o_full,
  output logic       o_busy,
  output logic [2:0] o_dbg_state,
  output logic [3:0] o_dbg_in_transit
);

  // One shared timer serves both the open timeout and the guard interval.
  localparam int TMAX = (OPEN_CYCLES > GUARD_CYCLES) ? OPEN_CYCLES : GUARD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD_CYCLES - 1);
  localparam logic [3:0]    SLOTS_4    = 4'(SLOTS);

  localparam logic SIDE_ENTRY = 1'b0;
  localparam logic SIDE_EXIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENT_OPEN = 3'd1,
    ST_ENT_PASS = 3'd2,
    ST_EXT_OPEN = 3'd3,
    ST_EXT_PASS = 3'd4,
    ST_GUARD    = 3'd5
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_last_served;
  logic          r_cur_side;
  logic          r_entry_open;
  logic          r_exit_open;
  logic          r_busy;
  logic [3:0]    r_free_q;
  logic [3:0]    r_in_transit;
  logic [3:0]    r_avail;
  logic          r_full;

  logic [3:0]    w_free_clamped;
  logic          w_free_drop;
  logic          w_entry_admit;
  logic [3:0]    w_in_transit_next;
  logic [3:0]    w_avail_next;
  logic          w_ent_ok;
  logic          w_ext_ok;
  logic          w_pick_entry;

  // Free count above the car-park size is treated as a full car park of free slots.
  always_comb begin
    w_free_clamped = i_free;
    if (i_free > SLOTS_4) begin
      w_free_clamped = SLOTS_4;
    end
  end

  // A car is admitted on the cycle its pass sensor is first seen while the entry gate is up.
  assign w_entry_admit = (r_state == ST_ENT_OPEN) && i_entry_pass;

  // A falling free count means a promised car has now taken its slot.
  assign w_free_drop = (w_free_clamped < r_free_q);

  // Update in_transit: +1 on admit (saturate at SLOTS), -1 on occupancy (floor 0).
  // When both happen together, they cancel.
  always_comb begin
    w_in_transit_next = r_in_transit;
    if (w_entry_admit && !w_free_drop) begin
      if (r_in_transit < SLOTS_4) begin
        w_in_transit_next = r_in_transit + 4'd1;
      end
    end else if (!w_entry_admit && w_free_drop) begin
      if (r_in_transit != 4'd0) begin
        w_in_transit_next = r_in_transit - 4'd1;
      end
    end
  end

  // Slots still offerable to new entries, saturating at zero.
  always_comb begin
    w_avail_next = 4'd0;
    if (r_free_q > r_in_transit) begin
      w_avail_next = r_free_q - r_in_transit;
    end
  end

  // Arbitration inputs for IDLE. On a tie, serve the side opposite the last one served.
  assign w_ent_ok     = i_entry_req && (r_avail != 4'd0);
  assign w_ext_ok     = i_exit_req;
  assign w_pick_entry = w_ent_ok && (!w_ext_ok || (r_last_served == SIDE_EXIT));

  // Vacancy bookkeeping: sample free count and track cars in transit.
  // The outputs lag these values by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_free_q     <= 4'd0;
      r_in_transit <= 4'd0;
      r_avail      <= 4'd0;
      r_full       <= 1'b1;
    end else begin
      r_free_q     <= w_free_clamped;
      r_in_transit <= w_in_transit_next;
      r_avail      <= w_avail_next;
      r_full       <= (w_avail_next == 4'd0);
    end
  end

  // Gate sequencing FSM with registered gate commands and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_last_served <= SIDE_EXIT;
      r_cur_side    <= SIDE_EXIT;
      r_entry_open  <= 1'b0;
      r_exit_open   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (w_pick_entry) begin
            r_state      <= ST_ENT_OPEN;
            r_cur_side   <= SIDE_ENTRY;
            r_entry_open <= 1'b1;
            r_busy       <= 1'b1;
          end else if (w_ext_ok) begin
            r_state     <= ST_EXT_OPEN;
            r_cur_side  <= SIDE_EXIT;
            r_exit_open <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        ST_ENT_OPEN: begin
          if (i_entry_pass) begin
            r_state <= ST_ENT_PASS;
            r_timer <= '0;
          end else if (r_timer == OPEN_LAST) begin
            r_state      <= ST_GUARD;
            r_timer      <= '0;
            r_entry_open <= 1'b0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        // Barrier stays up as long as a car is underneath; no timeout here.
        ST_ENT_PASS: begin
          if (!i_entry_pass) begin
            r_state      <= ST_GUARD;
            r_timer      <= '0;
            r_entry_open <= 1'b0;
          end
        end

        ST_EXT_OPEN: begin
          if (i_exit_pass) begin
            r_state <= ST_EXT_PASS;
            r_timer <= '0;
          end else if (r_timer == OPEN_LAST) begin
            r_state     <= ST_GUARD;
            r_timer     <= '0;
            r_exit_open <= 1'b0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        ST_EXT_PASS: begin
          if (!i_exit_pass) begin
            r_state     <= ST_GUARD;
            r_timer     <= '0;
            r_exit_open <= 1'b0;
          end
        end

        // Both barriers held down for GUARD_CYCLES; the served side is remembered on leaving.
        ST_GUARD: begin
          if (r_timer == GUARD_LAST) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_busy        <= 1'b0;
            r_last_served <= r_cur_side;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_timer      <= '0;
          r_entry_open <= 1'b0;
          r_exit_open  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign o_entry_open     = r_entry_open;
  assign o_exit_open      = r_exit_open;
  assign o_avail          = r_avail;
  assign o_full           = r_full;
  assign o_busy           = r_busy;
  assign o_dbg_state      = r_state;
  assign o_dbg_in_transit = r_in_transit;

endmodule
